// File: rtl/prim_ram_1p_adapter.sv
// Initiator-side controller for a single-port SRAM with one-cycle read latency.
// Provides a valid/ready request and response channel, response buffering and optional zero-fill after reset.
module prim_ram_1p_adapter #(
  parameter int Width           = 32,
  parameter int Depth           = 128,
  parameter int DataBitsPerMask = 1,
  parameter int RspDepth        = 2,
  parameter bit InitOnReset     = 1'b1,
  localparam int Aw             = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [Aw-1:0]    req_addr_i,
  input  logic [Width-1:0] req_wdata_i,
  input  logic [Width-1:0] req_wmask_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [Width-1:0] rsp_rdata_o,
  output logic             init_done_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic [Width-1:0] ram_rdata_i
);

  localparam int Cw         = $clog2(RspDepth + 1);
  localparam int Pw         = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int MaskGroups = (Width + DataBitsPerMask - 1) / DataBitsPerMask;
  localparam logic [Width-1:0] FullMask = Width'({(MaskGroups * DataBitsPerMask){1'b1}});

  typedef enum logic {INIT, ACTIVE} state_e;

  state_e           state;
  logic [Aw-1:0]    cnt;
  logic             inflight;
  logic [Width-1:0] fifo_mem [RspDepth];
  logic [Pw-1:0]    wptr;
  logic [Pw-1:0]    rptr;
  logic [Cw-1:0]    count;

  logic          active;
  logic          push;
  logic          pop;
  logic          rsp_avail;
  logic [Cw:0]   used;
  logic          rd_credit;
  logic          ready;
  logic          accept;

  function automatic logic [Pw-1:0] ptr_inc(input logic [Pw-1:0] p);
    return (p == Pw'(RspDepth - 1)) ? '0 : p + Pw'(1);
  endfunction

  assign active    = (state == ACTIVE);
  assign push      = inflight;
  assign rsp_avail = active && (count != '0);
  assign pop       = rsp_avail & rsp_ready_i;

  // Credits count buffered entries plus the read still inside the SRAM, so a full FIFO can never be pushed.
  assign used      = {1'b0, count} + (Cw+1)'(inflight) - (Cw+1)'(pop);
  assign rd_credit = used < (Cw+1)'(RspDepth);
  assign ready     = active & (req_write_i | rd_credit);
  assign accept    = req_valid_i & ready;

  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    init_done_o = 1'b0;
    ram_req_o   = 1'b0;
    ram_write_o = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_wmask_o = '0;
    if (rst_ni) begin
      if (state == INIT) begin
        ram_req_o   = 1'b1;
        ram_write_o = 1'b1;
        ram_addr_o  = cnt;
        ram_wmask_o = FullMask;
      end else begin
        req_ready_o = ready;
        rsp_valid_o = rsp_avail;
        rsp_rdata_o = fifo_mem[rptr];
        init_done_o = 1'b1;
        ram_req_o   = accept;
        ram_write_o = accept & req_write_i;
        ram_addr_o  = req_addr_i;
        ram_wdata_o = req_wdata_i;
        ram_wmask_o = req_wmask_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      if (InitOnReset) state <= INIT;
      else             state <= ACTIVE;
      cnt      <= '0;
      inflight <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      if (state == INIT) begin
        cnt <= cnt + Aw'(1);
        if (cnt == Aw'(Depth - 1)) state <= ACTIVE;
      end
      // The SRAM holds read data for one cycle only, so it is captured unconditionally.
      inflight <= active & accept & ~req_write_i;
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      count <= count + Cw'(push) - Cw'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && push) fifo_mem[wptr] <= ram_rdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(push && !pop && count == Cw'(RspDepth)));
      assert (!(active && ram_req_o && !accept));
      assert (!(state == INIT && req_ready_o));
    end
  end

endmodule

// File: tb/tb_prim_ram_1p_adapter.sv
// Directed bench for prim_ram_1p_adapter with a behavioural one-cycle-latency SRAM model.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_prim_ram_1p_adapter;
  localparam int W  = 32;
  localparam int D  = 128;
  localparam int AW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [W-1:0]  req_wdata = '0;
  logic [W-1:0]  req_wmask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [W-1:0]  rsp_rdata;
  logic          init_done;
  logic          ram_req;
  logic          ram_write;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_wdata;
  logic [W-1:0]  ram_wmask;
  logic [W-1:0]  ram_rdata = '0;

  logic [W-1:0]  mem [D];

  prim_ram_1p_adapter #(
    .Width(W), .Depth(D), .DataBitsPerMask(1), .RspDepth(2), .InitOnReset(1'b1)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .init_done_o(init_done),
    .ram_req_o(ram_req), .ram_write_o(ram_write), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_wmask_o(ram_wmask), .ram_rdata_i(ram_rdata)
  );

  // Second instance without zero-fill.
  logic          rst_n2 = 1'b0;
  logic          req_ready2, rsp_valid2, init_done2, ram_req2, ram_write2;
  logic [W-1:0]  rsp_rdata2, ram_wdata2, ram_wmask2;
  logic [AW-1:0] ram_addr2;
  logic          zero_bit = 1'b0;
  logic [AW-1:0] zero_addr = '0;
  logic [W-1:0]  zero_word = '0;

  prim_ram_1p_adapter #(
    .Width(W), .Depth(D), .DataBitsPerMask(1), .RspDepth(2), .InitOnReset(1'b0)
  ) u_noinit (
    .clk_i(clk), .rst_ni(rst_n2),
    .req_valid_i(zero_bit), .req_ready_o(req_ready2), .req_write_i(zero_bit),
    .req_addr_i(zero_addr), .req_wdata_i(zero_word), .req_wmask_i(zero_word),
    .rsp_valid_o(rsp_valid2), .rsp_ready_i(zero_bit), .rsp_rdata_o(rsp_rdata2),
    .init_done_o(init_done2),
    .ram_req_o(ram_req2), .ram_write_o(ram_write2), .ram_addr_o(ram_addr2),
    .ram_wdata_o(ram_wdata2), .ram_wmask_o(ram_wmask2), .ram_rdata_i(zero_word)
  );

  initial begin
    for (int i = 0; i < D; i++) mem[i] = 32'hA5A5_A5A5;
  end

  always @(posedge clk) begin
    if (ram_req) begin
      if (ram_write) mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
      else           ram_rdata <= mem[ram_addr];
    end
  end

  task automatic drive_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
  endtask

  task automatic drive_read(input logic [AW-1:0] a);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
  endtask

  task automatic drive_idle();
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({ram_req, ram_write, req_ready, init_done, rsp_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {ram_req, ram_write, req_ready, init_done, rsp_valid});
    end
  endtask

  task automatic test_init();
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      #1;
      checks++;
      if ({ram_req, ram_write, ram_addr, ram_wdata, ram_wmask, req_ready, init_done, rsp_valid} !==
          {1'b1, 1'b1, AW'(i), 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL init_cycle%0d: got req=%b wr=%b addr=%0d wdata=%h wmask=%h rdy=%b done=%b expected 1 1 %0d 0 ffffffff 0 0",
                 i, ram_req, ram_write, ram_addr, ram_wdata, ram_wmask, req_ready, init_done, i);
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({init_done, ram_req} !== 2'b10) begin
      errors++;
      $display("FAIL init_done_129: got done=%b ram_req=%b expected 1 0", init_done, ram_req);
    end
  endtask

  task automatic test_init_read();
    drive_read(7'd5); #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL init_read_ready: got %b expected 1", req_ready); end
    drive_idle(); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL init_read_early: got %b expected 0", rsp_valid); end
    @(negedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL init_read_data: got v=%b d=%h expected 1 00000000", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_mask();
    drive_write(7'd3, 32'h1234_5678, 32'hFFFF_FFFF);
    drive_write(7'd3, 32'hDEAD_BEEF, 32'h0000_FFFF);
    drive_read(7'd3); #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL mask_read_ready: got %b expected 1", req_ready); end
    drive_idle(); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mask_read_early: got %b expected 0", rsp_valid); end
    @(negedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h1234_BEEF}) begin
      errors++; $display("FAIL mask_read_data: got v=%b d=%h expected 1 1234beef", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] expv [16];
    for (int i = 0; i < 16; i++) begin
      expv[i] = 32'h1000_0000 + i * 32'h0000_0101;
      drive_write(AW'(16 + i), expv[i], 32'hFFFF_FFFF);
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (k < 16) drive_read(AW'(16 + k));
      else        drive_idle();
      #1;
      if (k < 16) begin
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", k, req_ready); end
      end
      if (k >= 2) begin
        checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, expv[k-2]}) begin
          errors++; $display("FAIL b2b_rsp%0d: got v=%b d=%h expected 1 %h", k - 2, rsp_valid, rsp_rdata, expv[k-2]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    drive_write(7'd40, 32'h4000_00AA, 32'hFFFF_FFFF);
    drive_write(7'd41, 32'h4100_00BB, 32'hFFFF_FFFF);
    drive_write(7'd42, 32'h4200_00CC, 32'hFFFF_FFFF);
    drive_idle();
    rsp_ready = 1'b0;
    drive_read(7'd40); #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_accept0: got %b expected 1", req_ready); end
    drive_read(7'd41); #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_accept1: got %b expected 1", req_ready); end
    drive_read(7'd42); #1;
    checks++;
    if ({req_ready, ram_req} !== 2'b00) begin errors++; $display("FAIL bp_block_read: got rdy=%b req=%b expected 0 0", req_ready, ram_req); end
    checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h4000_00AA}) begin
      errors++; $display("FAIL bp_head_early: got v=%b d=%h expected 1 400000aa", rsp_valid, rsp_rdata);
    end
    drive_write(7'd50, 32'h5050_5050, 32'hFFFF_FFFF); #1;
    checks++;
    if ({req_ready, ram_req, ram_write} !== 3'b111) begin
      errors++; $display("FAIL bp_write_ok: got %b expected 111", {req_ready, ram_req, ram_write});
    end
    drive_read(7'd42); #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_still_blocked: got %b expected 0", req_ready); end
    checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h4000_00AA}) begin
      errors++; $display("FAIL bp_head_stable: got v=%b d=%h expected 1 400000aa", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
    rsp_ready = 1'b1; #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata} !== {2'b11, 32'h4000_00AA}) begin
      errors++; $display("FAIL bp_resume: got rdy=%b v=%b d=%h expected 1 1 400000aa", req_ready, rsp_valid, rsp_rdata);
    end
    drive_idle(); #1;
    checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h4100_00BB}) begin
      errors++; $display("FAIL bp_rsp1: got v=%b d=%h expected 1 410000bb", rsp_valid, rsp_rdata);
    end
    @(negedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h4200_00CC}) begin
      errors++; $display("FAIL bp_rsp2: got v=%b d=%h expected 1 420000cc", rsp_valid, rsp_rdata);
    end
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", rsp_valid); end
    checks++;
    if (mem[50] !== 32'h5050_5050) begin errors++; $display("FAIL bp_write_mem: got %h expected 50505050", mem[50]); end
  endtask

  task automatic test_reset_drop();
    logic saw_rsp;
    saw_rsp = 1'b0;
    drive_read(7'd5); #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rd_drop_accept: got %b expected 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0; rst_n = 1'b0; #1;
    checks++;
    if ({rsp_valid, ram_req, init_done} !== 3'b000) begin
      errors++; $display("FAIL rd_drop_in_reset: got %b expected 000", {rsp_valid, ram_req, init_done});
    end
    @(negedge clk);
    rst_n = 1'b1; #1;
    checks++;
    if ({ram_req, ram_write, ram_addr, init_done} !== {2'b11, 7'd0, 1'b0}) begin
      errors++; $display("FAIL rd_drop_init_restart: got req=%b wr=%b addr=%0d done=%b expected 1 1 0 0", ram_req, ram_write, ram_addr, init_done);
    end
    for (int i = 0; i < D + 4; i++) begin
      if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
      @(negedge clk); #1;
    end
    checks++;
    if (saw_rsp !== 1'b0) begin errors++; $display("FAIL rd_drop_no_rsp: got %b expected 0", saw_rsp); end
    checks++;
    if ({init_done, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL rd_drop_done: got done=%b v=%b expected 1 0", init_done, rsp_valid);
    end
  endtask

  task automatic test_no_init();
    logic saw_req;
    saw_req = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({init_done2, req_ready2, ram_req2} !== 3'b000) begin
      errors++; $display("FAIL noinit_in_reset: got %b expected 000", {init_done2, req_ready2, ram_req2});
    end
    @(negedge clk);
    rst_n2 = 1'b1; #1;
    checks++;
    if ({init_done2, req_ready2} !== 2'b11) begin
      errors++; $display("FAIL noinit_first_cycle: got done=%b rdy=%b expected 1 1", init_done2, req_ready2);
    end
    for (int i = 0; i < 8; i++) begin
      if (ram_req2 !== 1'b0) saw_req = 1'b1;
      @(negedge clk); #1;
    end
    checks++;
    if (saw_req !== 1'b0) begin errors++; $display("FAIL noinit_no_writes: got %b expected 0", saw_req); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_init_read();
    test_mask();
    test_back_to_back();
    test_backpressure();
    test_reset_drop();
    test_no_init();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prim_ram_1p_adapter.md
Name: prim_ram_1p_adapter

Overview:
Initiator-side controller for the team's synchronous single-port SRAM primitive. It converts a valid/ready request channel and a valid/ready read-response channel into the SRAM's req/write/addr/wdata/wmask port, whose read data arrives one cycle after the request. It buffers read responses under backpressure and can zero-fill the whole memory after reset. It sits between a bus/TL-UL device adapter and the SRAM instance.

Parameters:
Width, 32, data width in bits; must match the SRAM.
Depth, 128, number of SRAM words; address width Aw = $clog2(Depth).
DataBitsPerMask, 1, mask granularity; used only for the full-mask value during init.
RspDepth, 2, response FIFO entries; must be at least 1, and 2 gives full read throughput.
InitOnReset, 1, when 1, zero-fills all Depth words after reset.

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous reset, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid and ready are both high
req_write_i  in  1  1 = write, 0 = read
req_addr_i  in  Aw  word address
req_wdata_i  in  Width  write data
req_wmask_i  in  Width  full bit write mask
rsp_valid_o  out  1  read response valid
rsp_ready_i  in  1  read response accept
rsp_rdata_o  out  Width  read data
init_done_o  out  1  high once the adapter accepts requests
ram_req_o  out  1  SRAM request
ram_write_o  out  1  SRAM write enable
ram_addr_o  out  Aw  SRAM address
ram_wdata_o  out  Width  SRAM write data
ram_wmask_o  out  Width  SRAM write mask
ram_rdata_i  in  Width  SRAM read data, valid one cycle after a read request

Behaviour:
- Reset (rst_ni low at a clock edge) is synchronous.
  - FSM goes to INIT if InitOnReset=1, otherwise ACTIVE.
  - Init counter clears, FIFO empties, and the in-flight flag clears. A read in flight is dropped and its data is never returned.
  - While rst_ni is low, all outputs are 0.
- FSM states: INIT, ACTIVE. There is no path back to INIT except reset.
- INIT:
  - Each cycle drives ram_req_o=1, ram_write_o=1, ram_addr_o=cnt, ram_wdata_o=0, ram_wmask_o=all ones.
  - cnt runs 0..Depth-1; after the write at Depth-1 the FSM moves to ACTIVE. INIT lasts exactly Depth cycles.
  - During INIT: req_ready_o=0, init_done_o=0, rsp_valid_o=0.
- ACTIVE:
  - init_done_o=1.
  - Request path is combinational pass-through: ram_req_o = req_valid_i & req_ready_o; ram_write_o, ram_addr_o, ram_wdata_o and ram_wmask_o come from the req_* inputs.
  - When ram_req_o=0, ram_write_o is 0 and the data, address and mask outputs are don't-care.
- Ready rule:
  - Writes: req_ready_o=1.
  - Reads: req_ready_o = (count + inflight - pop) < RspDepth, where pop = rsp_valid_o & rsp_ready_i. req_ready_o may depend on req_write_i.
  - Writes are posted and produce no response.
- Read timing:
  - Read accepted at cycle T: the inflight flag is set at T+1; ram_rdata_i is sampled at the end of T+1 and pushed into the FIFO.
  - rsp_valid_o rises at T+2. Latency from accept to response is 2 cycles.
- Responses are returned strictly in request order.
- rsp_rdata_o is the FIFO head. It is stable while rsp_valid_o=1 and rsp_ready_i=0.
- A push and a pop in the same cycle leave count unchanged. The FIFO never overflows because of the credit rule; an overflow is an assertion failure.
- Mixed traffic: a write accepted at T+1 while a read is in flight is legal. The SRAM holds that read's data for one cycle only, so it is captured at T+1 regardless.
- Address ≥ Depth is passed through unchanged; the result is undefined and is the caller's responsibility.
- Assertions:
  - No push into a full FIFO.
  - ram_req_o is never high in ACTIVE without an accepted request.
  - req_ready_o is low during INIT.

Test Plan:
- Depth=128, InitOnReset=1, release reset -> ram_req_o and ram_write_o high for exactly 128 cycles with addresses 0..127, init_done_o rises on the 129th cycle; then a read of addr 5 returns 0x00000000.
- Write 0x12345678 to addr 3, then write 0xDEADBEEF with mask 0x0000FFFF to addr 3, then read addr 3 -> rsp_rdata_o=0x1234BEEF, rsp_valid_o 2 cycles after accept.
- 16 back-to-back reads with rsp_ready_i=1, RspDepth=2 -> req_ready_o stays 1, one response per cycle, in order.
- rsp_ready_i=0, issue reads -> exactly 2 reads accepted, then req_ready_o=0 for reads while writes are still accepted; raise rsp_ready_i -> 2 responses in order, reads resume.
- Assert rst_ni low for one cycle the cycle after a read accept -> no response ever appears, rsp_valid_o=0, INIT restarts at addr 0.
- InitOnReset=0 -> init_done_o=1 and req_ready_o=1 the first cycle after reset, no SRAM writes issued.
